// File: rtl/multiplier.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock, WIDTH clocks per product.
// The product register only updates when a computation completes, so o never shows partial sums.
module multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] o,
    output logic               out_ready
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_lat_q, a_lat_d;
    logic [WIDTH-1:0] b_lat_q, b_lat_d;
    logic [PW-1:0]    o_q, o_d;
    logic             rdy_q, rdy_d;
    logic [PW-1:0]    sum;
    logic             load;

    always_comb begin
        sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        a_lat_d  = a_lat_q;
        b_lat_d  = b_lat_q;
        o_d      = o_q;
        rdy_d    = rdy_q;
        load     = 1'b0;

        case (state_q)
            IDLE: load = 1'b1;
            CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    o_d     = sum;
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
            end
            // Any operand change restarts the computation; o keeps the old product meanwhile.
            DONE: load = (a != a_lat_q) || (b != b_lat_q);
            default: state_d = IDLE;
        endcase

        if (load) begin
            a_lat_d  = a;
            b_lat_d  = b;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            rdy_d    = 1'b0;
            state_d  = CALC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            a_lat_q  <= '0;
            b_lat_q  <= '0;
            o_q      <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            a_lat_q  <= a_lat_d;
            b_lat_q  <= b_lat_d;
            o_q      <= o_d;
            rdy_q    <= rdy_d;
        end
    end

    assign o         = o_q;
    assign out_ready = rdy_q;
endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: timeline model of when each product must appear, directed scenarios,
// exhaustive sweep with reset between pairs, and a randomized operand/reset phase.
module tb_multiplier;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   a   = '0;
    logic [W-1:0]   b   = '0;
    logic [2*W-1:0] o;
    logic           out_ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .o         (o),
        .out_ready (out_ready)
    );

    // Model: a product of the operands seen at the start edge must appear W edges later.
    int             edge_no = 0;
    bit             started = 1'b0;
    int             lat_a   = 0;
    int             lat_b   = 0;
    int             done_at = -1;
    logic [2*W-1:0] exp_o   = '0;
    bit             exp_rdy = 1'b0;

    always @(negedge rst) begin
        started = 1'b0;
        exp_o   = '0;
        exp_rdy = 1'b0;
        done_at = -1;
    end

    always @(posedge clk) begin
        edge_no++;
        if (rst === 1'b1) begin
            if (!started) begin
                started = 1'b1;
                lat_a   = int'(a);
                lat_b   = int'(b);
                done_at = edge_no + W;
            end else if (edge_no == done_at) begin
                exp_o   = (2*W)'(lat_a * lat_b);
                exp_rdy = 1'b1;
            end else if (exp_rdy && (int'(a) != lat_a || int'(b) != lat_b)) begin
                lat_a   = int'(a);
                lat_b   = int'(b);
                exp_rdy = 1'b0;
                done_at = edge_no + W;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (o !== exp_o || out_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL model t=%0t: o=%0d out_ready=%0b, want o=%0d out_ready=%0b",
                     $time, o, out_ready, exp_o, exp_rdy);
        end
    end

    task automatic check(input string name, input logic [2*W-1:0] want_o, input logic want_r,
                         input bit quiet);
        vectors++;
        if (o !== want_o || out_ready !== want_r) begin
            miscompares++;
            $display("FAIL %s: o=%0d out_ready=%0b, want o=%0d out_ready=%0b",
                     name, o, out_ready, want_o, want_r);
        end else if (!quiet) begin
            $display("ok   %s: o=%0d out_ready=%0b", name, o, out_ready);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns just after reset release; the next rising edge is edge 1.
    task automatic reset_start(input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        #2 rst = 1'b0;
        a = va;
        b = vb;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        a = 4'd13;
        b = 4'd10;
        #50 check("reset_state", 8'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("13x10_edge%0d", k), 8'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("13x10_edge5", 8'd130, 1'b1, 1'b0);
        edges(2);
        check("13x10_hold", 8'd130, 1'b1, 1'b0);

        b = 4'd3;
        edges(1);
        check("b3_drop", 8'd130, 1'b0, 1'b0);
        edges(3);
        check("b3_calc_hold", 8'd130, 1'b0, 1'b0);
        edges(1);
        check("b3_done", 8'd39, 1'b1, 1'b0);

        reset_start(4'd15, 4'd15);
        edges(4);
        check("15x15_edge4", 8'd0, 1'b0, 1'b0);
        edges(1);
        check("15x15_edge5", 8'd225, 1'b1, 1'b0);

        reset_start(4'd0, 4'd9);
        edges(4);
        check("0x9_edge4", 8'd0, 1'b0, 1'b0);
        edges(1);
        check("0x9_edge5", 8'd0, 1'b1, 1'b0);

        reset_start(4'd13, 4'd10);
        edges(2);
        a = 4'd2;
        edges(3);
        check("a2_ignored", 8'd130, 1'b1, 1'b0);
        edges(1);
        check("a2_restart", 8'd130, 1'b0, 1'b0);
        edges(3);
        check("a2_calc_hold", 8'd130, 1'b0, 1'b0);
        edges(1);
        check("a2_done", 8'd20, 1'b1, 1'b0);

        b = 4'd3;
        edges(3);
        check("midcalc_before_rst", 8'd20, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check("async_reset", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        edges(4);
        check("after_rst_edge4", 8'd0, 1'b0, 1'b0);
        edges(1);
        check("after_rst_edge5", 8'd6, 1'b1, 1'b0);

        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                reset_start(W'(i), W'(j));
                edges(4);
                check($sformatf("sweep_%0dx%0d_edge4", i, j), 8'd0, 1'b0, 1'b1);
                edges(1);
                check($sformatf("sweep_%0dx%0d", i, j), (2*W)'(i * j), 1'b1, 1'b1);
            end
        end
        $display("sweep of %0d operand pairs complete", (1 << (2*W)));

        for (int c = 0; c < 2000; c++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end else if (r < 12) begin
                a = W'($urandom);
            end else if (r < 20) begin
                b = W'($urandom);
            end
        end
        edges(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
